// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: ALU op codes,
// sequencer states and the button op-select decode.
package calc_pkg;

    localparam int CMD_W     = 19;
    localparam int OPND_W    = 16;
    localparam int ALU_W     = 32;
    localparam int ALU_OP_W  = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Map the {btnl,btnc,btnr} selection onto the ALU operation code.
    function automatic logic [3:0] decode_op(input logic [2:0] sel);
        logic [3:0] code;
        case (sel)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SUB;
            3'b010:  code = ALU_AND;
            3'b011:  code = ALU_OR;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SLT;
            3'b110:  code = ALU_SLL;
            3'b111:  code = ALU_SRA;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/calc_seq_if.sv
// ALU bus between the sequencer (master) and the external ALU (slave).
interface calc_seq_if;
    import calc_pkg::*;

    logic [ALU_OP_W-1:0] alu_op;
    logic [ALU_W-1:0]    alu_a;
    logic [ALU_W-1:0]    alu_b;
    logic [ALU_W-1:0]    alu_result;

    modport master (output alu_op, output alu_a, output alu_b, input alu_result);
    modport slave  (input alu_op, input alu_a, input alu_b, output alu_result);
endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and an occupancy count.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the current flags and compute the next occupancy.
    always_comb begin
        do_push_s   = push & ~full_r;
        do_pop_s    = pop & ~empty_r;
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;
endmodule

// File: rtl/calc_seq.sv
// Calculator command sequencer: queues button-entered commands and replays
// them through the external ALU, one command per ISSUE/WB pair.
module calc_seq
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              btnu,
    input  logic              btnd,
    input  logic              btns,
    input  logic              btnl,
    input  logic              btnc,
    input  logic              btnr,
    input  logic [15:0]       sw,
    calc_seq_if.master        alu,
    output logic [15:0]       led,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);

    state_t              state_r;
    logic                push_prev_r;
    logic                run_prev_r;
    logic [OPND_W-1:0]   acc_r;
    logic [ALU_OP_W-1:0] alu_op_r;
    logic [ALU_W-1:0]    alu_a_r;
    logic [ALU_W-1:0]    alu_b_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                push_edge_s;
    logic                run_edge_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic [CMD_W-1:0]    head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [AW:0]         fifo_count_s;
    logic                unused_result_hi_s;

    // Edge detection and FIFO request qualification; pushes only land while idle.
    always_comb begin
        push_edge_s = btnd & ~push_prev_r;
        run_edge_s  = btns & ~run_prev_r;
        if (state_r == ST_IDLE) begin
            fifo_push_s = push_edge_s & ~fifo_full_s;
        end else begin
            fifo_push_s = 1'b0;
        end
        if (state_r == ST_ISSUE) begin
            fifo_pop_s = 1'b1;
        end else begin
            fifo_pop_s = 1'b0;
        end
    end

    calc_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .srst    (btnu),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .wr_data ({btnl, btnc, btnr, sw}),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Sequencer FSM with registered ALU operands, accumulator and status.
    always_ff @(posedge clk) begin
        if (btnu) begin
            state_r     <= ST_IDLE;
            push_prev_r <= 1'b0;
            run_prev_r  <= 1'b0;
            acc_r       <= 16'h0000;
            alu_op_r    <= 4'h0;
            alu_a_r     <= 32'h0000_0000;
            alu_b_r     <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            push_prev_r <= btnd;
            run_prev_r  <= btns;
            done_r      <= 1'b0;
            if (push_edge_s && (state_r != ST_IDLE || fifo_full_s)) err_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (run_edge_s) begin
                        busy_r <= 1'b1;
                        // A push accepted in this same cycle makes the run non-empty.
                        if (fifo_empty_s && !fifo_push_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_op_r <= decode_op(head_s[18:16]);
                    alu_a_r  <= sext16(acc_r);
                    alu_b_r  <= sext16(head_s[15:0]);
                    state_r  <= ST_WB;
                end
                ST_WB: begin
                    acc_r <= alu.alu_result[15:0];
                    if (fifo_count_s == '0) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign unused_result_hi_s = ^alu.alu_result[31:16];

    assign alu.alu_op = alu_op_r;
    assign alu.alu_a  = alu_a_r;
    assign alu.alu_b  = alu_b_r;
    assign led        = acc_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign full       = fifo_full_s;
    assign empty      = fifo_empty_s;
    assign err        = err_r;
endmodule

// File: doc/calc_seq.md
# calc_seq

Command sequencer for the calculator datapath. Operator entries (3-bit op select plus 16-bit operand) are captured on button edges into a small command queue; a run request replays them in order through the external ALU, one command per two cycles, and accumulates the results. It sits between the board buttons/switches and the ALU, replacing single-step button accumulation with batched execution.

## Interface
- DEPTH, 4, command queue entries (power of two, ≥2)
- clk  in  1  system clock, all logic on rising edge
- btnu  in  1  reset, synchronous, active-high
- btnd  in  1  push command (level; rising edge acts)
- btns  in  1  run queued program (level; rising edge acts)
- btnl, btnc, btnr  in  1 each  op select {btnl,btnc,btnr}, sampled with push
- sw  in  16  operand, sampled with push
- alu_op  out  4  ALU operation code, registered
- alu_a  out  32  ALU op1 = sign-extended accumulator, registered
- alu_b  out  32  ALU op2 = sign-extended queued operand, registered
- alu_result  in  32  combinational ALU result
- led  out  16  accumulator
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at end of run
- full, empty  out  1 each  queue flags
- err  out  1  sticky: push dropped (full or busy)

## Operation
- Reset values: led=0, alu_op=0, alu_a=0, alu_b=0, busy=0, done=0, full=0, empty=1, err=0, queue count=0, edge-detect registers=0.
- Edge detect: per button, prev register; edge = btn & ~prev.
- Op decode {l,c,r}: 000 ADD(0010), 001 SUB(0110), 010 AND(0000), 011 OR(0001), 100 XOR(0111), 101 SLT(0100), 110 SLL(1000), 111 SRA(1010).
- Push edge in IDLE with queue not full: write {op3, sw} at tail, count+1. Push when full or busy: dropped, err=1 until reset.
- FSM:
  - IDLE: run edge -> ISSUE (empty queue -> DONE).
  - ISSUE: pop head; register alu_op=decode(op3), alu_a=sext(led), alu_b=sext(operand) -> WB.
  - WB: led <= alu_result[15:0]; queue empty -> DONE, else -> ISSUE.
  - DONE: done=1 for this cycle -> IDLE.
- Run edge while busy: ignored, no error.
- Queue pointers wrap modulo DEPTH; count has log2(DEPTH)+1 bits; full = (count==DEPTH).
- Accumulator persists across runs; only btnu clears it.

## Timing
- Push edge sampled at cycle n: entry and flags updated from n+1.
- Push and run edges in the same IDLE cycle: push is accepted first, and the run includes the new entry.
- Run edge at cycle n: ISSUE at n+1, WB at n+2, led valid from n+3.
- K commands: last led update visible at n+1+2K, done high during cycle n+1+2K, busy low from n+2+2K.
- Empty run: DONE at n+1, done pulse, led unchanged.
- btnu during any state: next edge forces all reset values; queue contents discarded.

## Structure
- Package calc_pkg: ALU op code localparams, FSM state enum (IDLE, ISSUE, WB, DONE), op-select decode function.
- One sub-module: calc_cmd_fifo (parameterised DEPTH×19-bit synchronous FIFO with full/empty/count).
- The ALU stays external and is connected by the integrating top.

## Test plan
- Reset with btnu high for 2 cycles -> led=0x0000, empty=1, busy=0, err=0.
- Push OR 0x1234, AND 0x0ff0, ADD 0x324f, SUB 0x2d31, then run -> led steps 0x1234, 0x0230, 0x347f, 0x074e; done at run+9.
- Push XOR 0xffff, SLT 0x7346, SLL 0x0004, SRA 0x0004 on the prior accumulator 0x074e, then run -> led steps 0xf8b1, 0x0001, 0x0010, 0x0001.
- Five pushes with DEPTH=4 -> full=1 after the 4th, 5th dropped, err=1, run executes exactly 4 commands.
- Run with empty queue -> done pulse at run+1, led unchanged; push during busy -> dropped, err=1.
- Assert btnu during WB of the 2nd command -> next cycle led=0, empty=1, busy=0, no done pulse.
